mole_scheduler: RTL

Parametrised mole generator for the whack-a-mole game: picks a pseudo-random hole out of `NUM_HOLES`, lights it for a difficulty-dependent random time, then pauses for a random gap before the next mole. It scores the player's whacks as hit, wrong-hit or miss. It sits between the button/debounce front end and the score/display logic.

---
 rtl/mole_pkg.sv | 13 +
 rtl/lfsr_galois.sv | 22 ++
 rtl/mole_scheduler.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mole_pkg.sv
// Shared FSM state type and LFSR constants for the whack-a-mole scheduler.
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SHOW
    } state_t;

    localparam int                LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shift Galois LFSR; the low bit selects whether the tap mask is applied.
module lfsr_galois
    import mole_pkg::*;
#(
    parameter int               WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] MASK  = WIDTH'(LFSR_MASK),
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] state
);

    // NOTE: non-blocking assignment, so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= SEED;
        else
            state <= (state >> 1) ^ (state[0] ? MASK : '0);
    end

endmodule

// File: rtl/mole_scheduler.sv
// Whack-a-mole scheduler: random hole, random on-time and gap, hit/wrong-hit/miss scoring.
// Optional MOLE_NO_REPEAT_EN: never light the same hole twice in a row.
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int          NUM_HOLES = 8,
    parameter int          TIME_W    = 16,
    parameter int          SHOW_BASE = 512,
    parameter int          GAP_BASE  = 256,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    input  logic                 enable,
    input  logic                 tick,
    input  logic [1:0]           difficulty,
    input  logic [NUM_HOLES-1:0] hit,
    output logic [NUM_HOLES-1:0] mole,
    output logic                 mole_hit,
    output logic                 wrong_hit,
    output logic                 mole_miss
);

    localparam int IW = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;

    state_t                state;
    logic [TIME_W-1:0]     count;
    logic [LFSR_W-1:0]     lfsr;
    logic [IW-1:0]         idx_raw;
    logic [IW-1:0]         idx_red;
    logic [IW-1:0]         idx_sel;
    logic [NUM_HOLES-1:0]  mole_nxt;
    logic [TIME_W-1:0]     rnd_t;
    logic [TIME_W-1:0]     show_len;
    logic [TIME_W-1:0]     gap_len;
    logic                  expire;
    logic                  hit_active;
    logic                  hit_other;
    logic                  unused_bits;
`ifdef MOLE_NO_REPEAT_EN
    logic [IW-1:0]         prev_idx;
`endif

    lfsr_galois #(
        .WIDTH (LFSR_W),
        .MASK  (LFSR_MASK),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (CLK100MHZ),
        .rst_n (CPU_RESETN),
        .state (lfsr)
    );

    assign unused_bits = ^lfsr;

    // idx_raw < 2*NUM_HOLES, so one conditional subtraction folds it into range.
    assign idx_raw = lfsr[IW-1:0];
    assign idx_red = (int'(idx_raw) >= NUM_HOLES) ? IW'(int'(idx_raw) - NUM_HOLES) : idx_raw;

    // NOTE: default assignment first, so this always_comb cannot infer a latch.
    always_comb begin
        idx_sel = idx_red;
`ifdef MOLE_NO_REPEAT_EN
        if (idx_red == prev_idx)
            idx_sel = (int'(idx_red) == NUM_HOLES - 1) ? '0 : idx_red + IW'(1);
`endif
    end

    assign mole_nxt   = NUM_HOLES'(1) << idx_sel;
    assign rnd_t      = TIME_W'(lfsr[10:8]);
    assign show_len   = (TIME_W'(SHOW_BASE) >> difficulty) + rnd_t + TIME_W'(1);
    assign gap_len    = TIME_W'(GAP_BASE) + rnd_t + TIME_W'(1);
    assign expire     = tick && (count == TIME_W'(1));
    assign hit_active = |(hit & mole);
    assign hit_other  = |(hit & ~mole);

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state     <= IDLE;
            count     <= '0;
            mole      <= '0;
            mole_hit  <= 1'b0;
            wrong_hit <= 1'b0;
            mole_miss <= 1'b0;
`ifdef MOLE_NO_REPEAT_EN
            prev_idx  <= '0;
`endif
        end else begin
            // Pulses fall back low every cycle unless re-asserted below.
            mole_hit  <= 1'b0;
            wrong_hit <= 1'b0;
            mole_miss <= 1'b0;
            if (tick && count != '0)
                count <= count - TIME_W'(1);

            if (!enable) begin
                state <= IDLE;
                mole  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= GAP;
                        count <= gap_len;
                    end
                    GAP: begin
                        if (|hit)
                            wrong_hit <= 1'b1;
                        if (expire) begin
                            state    <= SHOW;
                            count    <= show_len;
                            mole     <= mole_nxt;
`ifdef MOLE_NO_REPEAT_EN
                            prev_idx <= idx_sel;
`endif
                        end
                    end
                    SHOW: begin
                        // A hit on the active hole wins over stray bits and over expiry.
                        if (hit_active) begin
                            mole_hit <= 1'b1;
                            mole     <= '0;
                            state    <= GAP;
                            count    <= gap_len;
                        end else begin
                            if (hit_other)
                                wrong_hit <= 1'b1;
                            if (expire) begin
                                mole_miss <= 1'b1;
                                mole      <= '0;
                                state     <= GAP;
                                count     <= gap_len;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        mole  <= '0;
                    end
                endcase
            end
        end
    end

endmodule
